// File: rtl/frac_step_pkg.sv
// Shared types, FSM encoding and round-robin helper
// for the fractional-step scheduler.
package frac_step_pkg;

  localparam int FS_HW   = 12;
  localparam int FS_LW   = 22;
  localparam int FS_NMAX = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic [FS_HW-1:0] h;
    logic [FS_LW-1:0] l;
    logic [FS_HW-1:0] kh;
    logic [FS_LW-1:0] kl;
  } ctx_t;

  // First set bit of en after ptr, circular over n channels.
  function automatic logic [3:0] rr_next(
    input logic [FS_NMAX-1:0] en,
    input logic [3:0]         ptr,
    input int                 n
  );
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 1; i <= FS_NMAX; i++) begin
      idx = (int'(ptr) + i) % n;
      if (!found && i <= n && en[idx]) begin
        res   = 4'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/frac_step_lane.sv
// Combinational single step of the (h, l) accumulator
// with carry on l >= WL.
module frac_step_lane #(
  parameter int             HW = 12,
  parameter int             LW = 22,
  parameter logic [LW-1:0]  WL = LW'(22'h100000)
) (
  input  logic [HW-1:0] h,
  input  logic [LW-1:0] l,
  input  logic [HW-1:0] kh,
  input  logic [LW-1:0] kl,
  output logic [HW-1:0] h_n,
  output logic [LW-1:0] l_n,
  output logic          carry
);

  assign carry = (l >= WL);
  assign h_n   = h + kh + HW'(carry);
  assign l_n   = l + kl - (carry ? WL : '0);

endmodule

// File: rtl/frac_step_sched.sv
// Round-robin fractional-step scheduler with valid/ready output.
// Optional per-channel carry counters: FRAC_STEP_SCHED_CARRY_CNT_EN.
module frac_step_sched
  import frac_step_pkg::*;
#(
  parameter int            NCH = 4,
  parameter int            HW  = FS_HW,
  parameter int            LW  = FS_LW,
  parameter logic [LW-1:0] WL  = LW'(22'h100000)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_we,
  input  logic [$clog2(NCH)-1:0]  cfg_ch,
  input  logic [HW-1:0]           cfg_kh,
  input  logic [LW-1:0]           cfg_kl,
  input  logic                    cfg_clr,
  input  logic [NCH-1:0]          ch_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic [HW-1:0]           out_h,
  output logic                    out_carry
`ifdef FRAC_STEP_SCHED_CARRY_CNT_EN
  ,
  output logic [NCH*8-1:0]        carry_cnt
`endif
);

  localparam int CW = $clog2(NCH);

  ctx_t          r_ctx [NCH];
  logic [0:0]    r_state;
  logic [CW-1:0] r_ptr;
  logic [CW-1:0] r_ch;
  logic [HW-1:0] r_h;
  logic          r_carry;

  logic          w_any;
  logic          w_grant;
  logic          w_cfg_ok;
  logic [CW-1:0] w_gch;
  ctx_t          w_gctx;
  logic [HW-1:0] w_h_n;
  logic [LW-1:0] w_l_n;
  logic          w_carry;

  assign w_any    = |ch_en;
  assign w_grant  = w_any && ((r_state == ST_IDLE) || out_ready);
  assign w_gch    = CW'(rr_next(FS_NMAX'(ch_en), 4'(r_ptr), NCH));
  assign w_gctx   = r_ctx[w_gch];
  assign w_cfg_ok = (int'(cfg_ch) < NCH);

  frac_step_lane #(
    .HW (HW),
    .LW (LW),
    .WL (WL)
  ) u_lane (
    .h     (w_gctx.h),
    .l     (w_gctx.l),
    .kh    (w_gctx.kh),
    .kl    (w_gctx.kl),
    .h_n   (w_h_n),
    .l_n   (w_l_n),
    .carry (w_carry)
  );

  // Config is applied after the step so a same-cycle clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_ctx[i] <= '0;
      r_state <= ST_IDLE;
      r_ptr   <= CW'(NCH - 1);
      r_ch    <= '0;
      r_h     <= '0;
      r_carry <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ctx[w_gch].h <= w_h_n;
        r_ctx[w_gch].l <= w_l_n;
        r_ptr   <= w_gch;
        r_ch    <= w_gch;
        r_h     <= w_h_n;
        r_carry <= w_carry;
        r_state <= ST_HOLD;
      end else if (out_ready) begin
        r_state <= ST_IDLE;
      end
      if (cfg_we && w_cfg_ok) begin
        r_ctx[cfg_ch].kh <= cfg_kh;
        r_ctx[cfg_ch].kl <= cfg_kl;
        if (cfg_clr) begin
          r_ctx[cfg_ch].h <= '0;
          r_ctx[cfg_ch].l <= '0;
        end
      end
    end
  end

  assign out_valid = (r_state == ST_HOLD);
  assign out_ch    = r_ch;
  assign out_h     = r_h;
  assign out_carry = r_carry;

`ifdef FRAC_STEP_SCHED_CARRY_CNT_EN
  logic [7:0] r_ccnt [NCH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_ccnt[i] <= '0;
    end else begin
      if (w_grant && w_carry && r_ccnt[w_gch] != 8'hFF)
        r_ccnt[w_gch] <= r_ccnt[w_gch] + 8'd1;
      if (cfg_we && w_cfg_ok && cfg_clr)
        r_ccnt[cfg_ch] <= '0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_cc
    assign carry_cnt[g*8 +: 8] = r_ccnt[g];
  end
`endif

endmodule

// File: tb/tb_frac_step_sched.sv
// Self-checking bench for frac_step_sched: directed cases
// plus randomized traffic against a behavioural model.
module tb_frac_step_sched;

  localparam int            NCH = 4;
  localparam int            HW  = 12;
  localparam int            LW  = 22;
  localparam logic [LW-1:0] WL  = 22'h100000;
  localparam int unsigned   HM  = (1 << HW) - 1;
  localparam int unsigned   LM  = (1 << LW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [HW-1:0]  cfg_kh = '0;
  logic [LW-1:0]  cfg_kl = '0;
  logic           cfg_clr = 1'b0;
  logic [NCH-1:0] ch_en = '0;
  logic           out_ready = 1'b0;
  logic           out_valid;
  logic [1:0]     out_ch;
  logic [HW-1:0]  out_h;
  logic           out_carry;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  frac_step_sched #(
    .NCH (NCH), .HW (HW), .LW (LW), .WL (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_kh    (cfg_kh),
    .cfg_kl    (cfg_kl),
    .cfg_clr   (cfg_clr),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_h     (out_h),
    .out_carry (out_carry)
  );

  task automatic chk(input string n,
                     input longint unsigned a,
                     input longint unsigned e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  // Behavioural model: channel contexts and the one pending result.
  int unsigned mh [NCH];
  int unsigned ml [NCH];
  int unsigned mkh[NCH];
  int unsigned mkl[NCH];
  int          mptr;
  bit          mvalid;
  int          mch;
  int unsigned mh_out;
  bit          mcarry;

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      mh[c] = 0; ml[c] = 0; mkh[c] = 0; mkl[c] = 0;
    end
    mptr = NCH - 1; mvalid = 0;
    mch = 0; mh_out = 0; mcarry = 0;
  endtask

  task automatic model_step();
    bit grant;
    int g;
    grant = (ch_en != 0) && (!mvalid || out_ready);
    if (grant) begin
      g = -1;
      for (int i = 1; i <= NCH; i++)
        if (g < 0 && ch_en[(mptr + i) % NCH]) g = (mptr + i) % NCH;
      mcarry = (ml[g] >= int'(WL));
      if (mcarry) begin
        ml[g] = (ml[g] + mkl[g] - int'(WL)) & LM;
        mh[g] = (mh[g] + mkh[g] + 1) & HM;
      end else begin
        ml[g] = (ml[g] + mkl[g]) & LM;
        mh[g] = (mh[g] + mkh[g]) & HM;
      end
      mptr = g; mvalid = 1; mch = g; mh_out = mh[g];
    end else if (mvalid && out_ready) begin
      mvalid = 0;
    end
    if (cfg_we && int'(cfg_ch) < NCH) begin
      mkh[cfg_ch] = cfg_kh;
      mkl[cfg_ch] = cfg_kl;
      if (cfg_clr) begin
        mh[cfg_ch] = 0; ml[cfg_ch] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("m_valid", out_valid, mvalid);
        if (mvalid) begin
          chk("m_ch", out_ch, mch);
          chk("m_h", out_h, mh_out);
          chk("m_carry", out_carry, mcarry);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; ch_en = '0; out_ready = 0;
    cfg_we = 0; cfg_clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic cfg(input int ch, input int kh,
                     input int kl, input bit clr);
    cfg_we = 1; cfg_ch = 2'(ch);
    cfg_kh = HW'(kh); cfg_kl = LW'(kl); cfg_clr = clr;
    @(negedge clk);
    cfg_we = 0; cfg_clr = 0;
  endtask

  initial begin
    int e1h[4] = '{3, 6, 9, 13};
    int e1c[4] = '{0, 0, 0, 1};
    int e2h[3] = '{2, 4, 8};
    int e4h[3] = '{'hFFF, 'hFFE, 'hFFE};
    int e4c[3] = '{0, 0, 1};

    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_ch", out_ch, 0);
    chk("rst_h", out_h, 0);
    chk("rst_carry", out_carry, 0);

    // single channel
    cfg(0, 3, 364066, 0);
    out_ready = 1; ch_en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_h", out_h, e1h[i]);
      chk("t1_carry", out_carry, e1c[i]);
    end
    ch_en = '0;
    @(negedge clk);

    // round robin
    do_reset();
    cfg(0, 1, 0, 0);
    cfg(1, 2, 0, 0);
    cfg(2, 4, 0, 0);
    ch_en = 4'b0111; out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_ch", out_ch, i % 3);
      if (i >= 3) chk("rr_h", out_h, e2h[i-3]);
    end
    ch_en = '0;
    @(negedge clk);

    // backpressure
    ch_en = 4'b0111; out_ready = 0;
    @(negedge clk);
    chk("bp_ch0", out_ch, 0);
    chk("bp_h0", out_h, 3);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_ch", out_ch, 0);
      chk("bp_h", out_h, 3);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_ch1", out_ch, 1);
    chk("bp_h1", out_h, 6);
    @(negedge clk);
    chk("bp_ch2", out_ch, 2);
    chk("bp_h2", out_h, 12);
    ch_en = '0;
    @(negedge clk);

    // wrap and carry
    do_reset();
    cfg(0, 'hFFF, int'(WL) - 1, 0);
    ch_en = 4'b0001; out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wr_h", out_h, e4h[i]);
      chk("wr_carry", out_carry, e4c[i]);
    end
    ch_en = '0;
    @(negedge clk);

    // config write on the grant cycle
    do_reset();
    cfg(0, 3, 0, 0);
    ch_en = 4'b0001; out_ready = 1;
    cfg_we = 1; cfg_ch = 0; cfg_kh = 7; cfg_kl = 0;
    @(negedge clk);
    cfg_we = 0;
    chk("sc_old_k", out_h, 3);
    @(negedge clk);
    chk("sc_new_k", out_h, 10);
    ch_en = '0;
    @(negedge clk);
    cfg(1, 5, 0, 0);
    ch_en = 4'b0010;
    @(negedge clk);
    chk("cl_pre", out_h, 5);
    ch_en = '0;
    @(negedge clk);
    cfg(1, 5, 0, 1);
    ch_en = 4'b0010;
    @(negedge clk);
    chk("cl_ch", out_ch, 1);
    chk("cl_h", out_h, 5);
    ch_en = '0;
    @(negedge clk);

    // async reset while holding
    ch_en = 4'b0001; out_ready = 0;
    @(negedge clk);
    chk("ar_hold", out_valid, 1);
    #2 rst_n = 0;
    #1 chk("ar_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    chk("ar_valid2", out_valid, 1);
    chk("ar_ch", out_ch, 0);
    chk("ar_h", out_h, 0);
    ch_en = '0;
    @(negedge clk);

    // randomized traffic
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      cfg_we    = ($urandom % 4 == 0);
      cfg_ch    = 2'($urandom % NCH);
      cfg_kh    = HW'($urandom);
      cfg_kl    = LW'($urandom);
      cfg_clr   = ($urandom % 8 == 0);
      ch_en     = NCH'($urandom);
      out_ready = ($urandom % 4 != 0);
    end
    @(negedge clk);
    cfg_we = 0; ch_en = '0; out_ready = 1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
